// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - lsu_ctrl shared funct3 codes, FSM state encoding and size decode
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_e;

    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Unsigned variants only exist for loads.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - core request/response and data-memory port bundle for lsu_ctrl
interface lsu_ctrl_if #(parameter int ADDR_W = 32);

    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_we;
    logic [2:0]        i_funct3;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_st_data;
    logic              o_rsp_valid;
    logic [31:0]       o_ld_data;
    logic              o_fault;
    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-3:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_mask;
    logic [31:0]       i_mem_rdata;

    modport master (
        output i_req_valid, i_we, i_funct3, i_addr, i_st_data, i_mem_rdata,
        input  o_req_ready, o_rsp_valid, o_ld_data, o_fault,
               o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_mask
    );

    modport slave (
        input  i_req_valid, i_we, i_funct3, i_addr, i_st_data, i_mem_rdata,
        output o_req_ready, o_rsp_valid, o_ld_data, o_fault,
               o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_mask
    );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte mask, store lane shift and load extract/extend for lsu_ctrl
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [7:0]  m8_o,
    output logic [63:0] d64_o,
    output logic [31:0] ld_data_o
);

    logic [3:0]  ones;
    logic [4:0]  sh;
    logic [31:0] raw;

    always_comb begin
        ones = 4'b1111;
        case (funct3_i[1:0])
            2'b00:   ones = 4'b0001;
            2'b01:   ones = 4'b0011;
            default: ones = 4'b1111;
        endcase
    end

    assign sh    = {off_i, 3'b000};
    assign m8_o  = {4'b0000, ones} << off_i;
    assign d64_o = {32'h0, st_data_i} << sh;
    assign raw   = 32'({hi_i, lo_i} >> sh);

    always_comb begin
        ld_data_o = raw;
        case (funct3_i)
            F3_B:    ld_data_o = {{24{raw[7]}}, raw[7:0]};
            F3_H:    ld_data_o = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   ld_data_o = {24'h0, raw[7:0]};
            F3_HU:   ld_data_o = {16'h0, raw[15:0]};
            default: ld_data_o = raw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store request sequencer; LSU_CTRL_MISALIGN_SPLIT_EN enables two-beat crossing accesses
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    lsu_ctrl_if.slave bus
);

    if (DATA_W != 32) begin : g_data_w_check
        $error("lsu_ctrl: DATA_W must be 32");
    end

    lsu_state_e        state_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       st_q;
    logic              rsp_valid_q;
    logic              req_ready_q;
    logic              fault_q;
    logic [7:0]        m8;
    logic [63:0]       d64;
    logic [31:0]       ld_ext;
    logic [31:0]       lo_sel;
    logic [31:0]       hi_sel;
    logic [2:0]        req_span;
    logic              req_cross;
    logic              req_illegal;

    assign req_span    = {1'b0, bus.i_addr[1:0]} + size_bytes(bus.i_funct3);
    assign req_cross   = req_span > 3'd4;
    assign req_illegal = f3_illegal(bus.i_funct3, bus.i_we);

`ifdef LSU_CTRL_MISALIGN_SPLIT_EN
    logic              cross_q;
    logic [31:0]       lo_q;

    // Crossing loads: first word was captured in BEAT1, second is on the bus now.
    assign lo_sel = cross_q ? lo_q : bus.i_mem_rdata;
    assign hi_sel = cross_q ? bus.i_mem_rdata : 32'h0;
`else
    logic              unused_hi;

    assign lo_sel    = bus.i_mem_rdata;
    assign hi_sel    = 32'h0;
    assign unused_hi = ^{m8[7:4], d64[63:32]};
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= '0;
            st_q        <= 32'h0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            fault_q     <= 1'b0;
`ifdef LSU_CTRL_MISALIGN_SPLIT_EN
            cross_q     <= 1'b0;
            lo_q        <= 32'h0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.i_req_valid) begin
                        req_ready_q <= 1'b0;
                        we_q        <= bus.i_we;
                        f3_q        <= bus.i_funct3;
                        addr_q      <= bus.i_addr;
                        st_q        <= bus.i_st_data;
`ifdef LSU_CTRL_MISALIGN_SPLIT_EN
                        cross_q     <= req_cross;
                        if (req_illegal) begin
`else
                        if (req_illegal || req_cross) begin
`endif
                            fault_q     <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            state_q     <= S_BEAT0;
                        end
                    end
                end
                S_BEAT0: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
`ifdef LSU_CTRL_MISALIGN_SPLIT_EN
                    if (cross_q) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_BEAT1;
                    end
`endif
                end
`ifdef LSU_CTRL_MISALIGN_SPLIT_EN
                S_BEAT1: begin
                    lo_q        <= bus.i_mem_rdata;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
`endif
                S_RESP: begin
                    fault_q     <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    lsu_align u_align (
        .off_i     (addr_q[1:0]),
        .funct3_i  (f3_q),
        .st_data_i (st_q),
        .hi_i      (hi_sel),
        .lo_i      (lo_sel),
        .m8_o      (m8),
        .d64_o     (d64),
        .ld_data_o (ld_ext)
    );

    always_comb begin
        bus.o_mem_en    = 1'b0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = 32'h0;
        bus.o_mem_mask  = 4'h0;
        case (state_q)
            S_BEAT0: begin
                bus.o_mem_en    = 1'b1;
                bus.o_mem_we    = we_q;
                bus.o_mem_addr  = addr_q[ADDR_W-1:2];
                bus.o_mem_wdata = d64[31:0];
                bus.o_mem_mask  = m8[3:0];
            end
`ifdef LSU_CTRL_MISALIGN_SPLIT_EN
            S_BEAT1: begin
                bus.o_mem_en    = 1'b1;
                bus.o_mem_we    = we_q;
                bus.o_mem_addr  = addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1);
                bus.o_mem_wdata = d64[63:32];
                bus.o_mem_mask  = m8[7:4];
            end
`endif
            default: ;
        endcase
    end

    assign bus.o_req_ready = req_ready_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_fault     = fault_q;
    assign bus.o_ld_data   = (rsp_valid_q && !we_q && !fault_q) ? ld_ext : 32'h0;

endmodule
